// File: rtl/gpio_m2f_led_ctrl_pkg.sv
// rtl/gpio_m2f_led_ctrl_pkg.sv - shared constants, FSM state type and command decode (optional GPIO_LED_BLINK_EN)
package gpio_led_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DUTY_W   = 4;
  localparam int N_LED    = 4;

  localparam logic [DUTY_W-1:0] PWM_WRAP = 4'd14;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;

  localparam logic [NIBBLE_W-1:0] CMD_DUTY0  = 4'h0;
  localparam logic [NIBBLE_W-1:0] CMD_DUTY3  = 4'h3;
  localparam logic [NIBBLE_W-1:0] CMD_BLINK0 = 4'h4;
  localparam logic [NIBBLE_W-1:0] CMD_BLINK3 = 4'h7;
  localparam logic [NIBBLE_W-1:0] CMD_CLEAR  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_APPLY
  } state_t;

  // True for command codes that change registers; everything else raises CMD_ERR.
  function automatic logic cmd_known(input logic [NIBBLE_W-1:0] cmd);
    logic ok;
    ok = (cmd <= CMD_DUTY3) || (cmd == CMD_CLEAR);
`ifdef GPIO_LED_BLINK_EN
    ok = ok || ((cmd >= CMD_BLINK0) && (cmd <= CMD_BLINK3));
`endif
    return ok;
  endfunction

endpackage

// File: rtl/gpio_m2f_led_ctrl_if.sv
// rtl/gpio_m2f_led_ctrl_if.sv - MSS GPIO command pins and LED/status outputs
interface gpio_m2f_led_ctrl_if;
  logic       GPIO_0_M2F;
  logic       GPIO_1_M2F;
  logic       GPIO_2_M2F;
  logic       GPIO_3_M2F;
  logic       GPIO_4_M2F;
  logic [3:0] LED_OUT;
  logic       BUSY;
  logic       CMD_ERR;

  modport master (
    output GPIO_0_M2F, GPIO_1_M2F, GPIO_2_M2F, GPIO_3_M2F, GPIO_4_M2F,
    input  LED_OUT, BUSY, CMD_ERR
  );

  modport slave (
    input  GPIO_0_M2F, GPIO_1_M2F, GPIO_2_M2F, GPIO_3_M2F, GPIO_4_M2F,
    output LED_OUT, BUSY, CMD_ERR
  );
endinterface

// File: rtl/gpio_m2f_led_ctrl_sync.sv
// rtl/gpio_m2f_led_ctrl_sync.sv - single-bit multi-flop synchronizer
module gpio_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Shift the asynchronous input through DEPTH flops; stages clear on reset.
  always_ff @(posedge clk) begin
    if (!resetn) stages <= '0;
    else         stages <= {stages[DEPTH-2:0], d};
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/gpio_m2f_led_ctrl.sv
// rtl/gpio_m2f_led_ctrl.sv - GPIO nibble command decoder driving 4 PWM LEDs (optional GPIO_LED_BLINK_EN)
module gpio_m2f_led_ctrl
  import gpio_led_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PWM_PRESCALE = 64,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int BLINK_DIV    = 25000000
) (
  input logic                 FAB_CCC_GL0,
  input logic                 FAB_RESET_N,
  gpio_m2f_led_ctrl_if.slave  gpio
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("BLINK_DIV must be at least 1");
  end

  logic                strb_s;
  logic [NIBBLE_W-1:0] nib_s;
  logic [NIBBLE_W-1:0] nib_raw;

  assign nib_raw = {gpio.GPIO_4_M2F, gpio.GPIO_3_M2F, gpio.GPIO_2_M2F, gpio.GPIO_1_M2F};

  gpio_sync #(.DEPTH(SYNC_STAGES)) u_sync_strb (
    .clk(FAB_CCC_GL0), .resetn(FAB_RESET_N), .d(gpio.GPIO_0_M2F), .q(strb_s)
  );

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_sync_nib
    gpio_sync #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk(FAB_CCC_GL0), .resetn(FAB_RESET_N), .d(nib_raw[i]), .q(nib_s[i])
    );
  end

  // Edge detect is masked until the synchronizer has flushed after reset, so a
  // strobe held high through reset never looks like a fresh rise.
  logic       strb_d;
  logic [2:0] flush_cnt;
  logic       armed;
  logic       strb_edge;

  assign armed     = (flush_cnt == 3'(SYNC_STAGES + 1));
  assign strb_edge = strb_s & ~strb_d & armed;

  // Delayed strobe for edge detection and post-reset flush counter.
  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      strb_d    <= 1'b0;
      flush_cnt <= '0;
    end else begin
      strb_d <= strb_s;
      if (!armed) flush_cnt <= flush_cnt + 3'd1;
    end
  end

  state_t              state;
  logic [NIBBLE_W-1:0] cmd_q;
  logic [NIBBLE_W-1:0] data_q;
  logic [31:0]         to_cnt;
  logic                busy_q;
  logic                cmd_err_q;

  // Command FSM: command nibble, data nibble with timeout, one APPLY cycle.
  // CMD_ERR for an unknown code is raised on entry so it is high during APPLY.
  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      data_q    <= '0;
      to_cnt    <= '0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strb_edge) begin
            cmd_q  <= nib_s;
            to_cnt <= '0;
            state  <= ST_WAIT_DATA;
            busy_q <= 1'b1;
          end
        end
        ST_WAIT_DATA: begin
          if (strb_edge) begin
            data_q    <= nib_s;
            state     <= ST_APPLY;
            cmd_err_q <= ~cmd_known(cmd_q);
          end else if (to_cnt == 32'(TIMEOUT_CYC - 1)) begin
            to_cnt    <= '0;
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        ST_APPLY: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  logic [DUTY_W-1:0] duty [N_LED];
`ifdef GPIO_LED_BLINK_EN
  logic [N_LED-1:0]  blink;
`endif

  // Register writes land at the end of the APPLY cycle.
  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      for (int i = 0; i < N_LED; i++) duty[i] <= '0;
`ifdef GPIO_LED_BLINK_EN
      blink <= '0;
`endif
    end else if (state == ST_APPLY) begin
      if (cmd_q == CMD_CLEAR) begin
        for (int i = 0; i < N_LED; i++) duty[i] <= '0;
`ifdef GPIO_LED_BLINK_EN
        blink <= '0;
`endif
      end else if (cmd_q <= CMD_DUTY3) begin
        duty[cmd_q[1:0]] <= data_q;
`ifdef GPIO_LED_BLINK_EN
      end else if (cmd_q >= CMD_BLINK0 && cmd_q <= CMD_BLINK3) begin
        blink[cmd_q[1:0]] <= data_q[0];
`endif
      end
    end
  end

  logic [31:0]       pre_cnt;
  logic [DUTY_W-1:0] step;

  // Shared PWM step counter, 0..PWM_WRAP, advancing every PWM_PRESCALE cycles.
  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      pre_cnt <= '0;
      step    <= '0;
    end else if (pre_cnt == 32'(PWM_PRESCALE - 1)) begin
      pre_cnt <= '0;
      step    <= (step == PWM_WRAP) ? '0 : step + 4'd1;
    end else begin
      pre_cnt <= pre_cnt + 32'd1;
    end
  end

`ifdef GPIO_LED_BLINK_EN
  logic [31:0] blink_cnt;
  logic        phase;

  // Free-running blink phase, toggling every BLINK_DIV cycles.
  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end
`endif

  logic [N_LED-1:0] led_next;

  // Per-channel PWM compare, gated by the blink phase where enabled.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (duty[i] == '0)           led_next[i] = 1'b0;
      else if (duty[i] == DUTY_MAX) led_next[i] = 1'b1;
      else                          led_next[i] = (step < duty[i]);
`ifdef GPIO_LED_BLINK_EN
      if (blink[i]) led_next[i] = led_next[i] & phase;
`endif
    end
  end

  logic [N_LED-1:0] led_q;

  // Registered LED drive.
  always_ff @(posedge FAB_CCC_GL0) begin
    if (!FAB_RESET_N) led_q <= '0;
    else              led_q <= led_next;
  end

  assign gpio.LED_OUT = led_q;
  assign gpio.BUSY    = busy_q;
  assign gpio.CMD_ERR = cmd_err_q;

endmodule

// File: tb/tb_gpio_m2f_led_ctrl.sv
// tb/tb_gpio_m2f_led_ctrl.sv - directed self-checking bench for gpio_m2f_led_ctrl
module tb_gpio_m2f_led_ctrl;

  localparam int PRESCALE = 2;
  localparam int PERIOD   = 15 * PRESCALE;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  int   err_cnt;
  int   err_base;
  int   hi [4];

  gpio_m2f_led_ctrl_if bus ();

  gpio_m2f_led_ctrl #(
    .SYNC_STAGES(2), .PWM_PRESCALE(PRESCALE), .TIMEOUT_CYC(16), .BLINK_DIV(8)
  ) dut (
    .FAB_CCC_GL0(clk), .FAB_RESET_N(rst_n), .gpio(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle CMD_ERR is high, so a stretched pulse shows up as extra counts.
  always @(negedge clk) if (bus.CMD_ERR === 1'b1) err_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_nibble(input logic [3:0] n);
    @(negedge clk);
    bus.GPIO_1_M2F = n[0];
    bus.GPIO_2_M2F = n[1];
    bus.GPIO_3_M2F = n[2];
    bus.GPIO_4_M2F = n[3];
    repeat (2) @(negedge clk);
    bus.GPIO_0_M2F = 1'b1;
    repeat (4) @(negedge clk);
    bus.GPIO_0_M2F = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [3:0] d);
    send_nibble(c);
    send_nibble(d);
  endtask

  task automatic measure(input int cycles);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    repeat (cycles) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (bus.LED_OUT[i] === 1'b1) hi[i]++;
    end
  endtask

  initial begin
    tests = 0; failed = 0; err_cnt = 0;
    rst_n = 1'b0;
    bus.GPIO_0_M2F = 1'b0;
    bus.GPIO_1_M2F = 1'b0;
    bus.GPIO_2_M2F = 1'b0;
    bus.GPIO_3_M2F = 1'b0;
    bus.GPIO_4_M2F = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", int'(bus.LED_OUT), 0);
    check("reset_busy", int'(bus.BUSY), 0);
    check("reset_cmd_err", int'(bus.CMD_ERR), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Duty 10 on LED2.
    err_base = err_cnt;
    send_cmd(4'h2, 4'hA);
    check("led2_busy_done", int'(bus.BUSY), 0);
    check("led2_no_err", err_cnt - err_base, 0);
    repeat (2) @(negedge clk);
    measure(PERIOD);
    check("led2_high", hi[2], 10 * PRESCALE);
    check("led0_off", hi[0], 0);
    check("led1_off", hi[1], 0);
    check("led3_off", hi[3], 0);

    // Timeout after command 0x1.
    err_base = err_cnt;
    send_nibble(4'h1);
    check("timeout_busy_wait", int'(bus.BUSY), 1);
    repeat (30) @(negedge clk);
    check("timeout_err_once", err_cnt - err_base, 1);
    check("timeout_busy_fall", int'(bus.BUSY), 0);
    measure(PERIOD);
    check("timeout_led1_same", hi[1], 0);
    check("timeout_led2_same", hi[2], 10 * PRESCALE);

    // Unknown command 0x9.
    err_base = err_cnt;
    send_cmd(4'h9, 4'h3);
    check("bad9_err_once", err_cnt - err_base, 1);
    measure(PERIOD);
    check("bad9_led2_same", hi[2], 10 * PRESCALE);
    check("bad9_led3_same", hi[3], 0);

    // Duty 15 on LED0, then clear.
    send_cmd(4'h0, 4'hF);
    repeat (2) @(negedge clk);
    measure(PERIOD);
    check("full_led0", hi[0], PERIOD);
    err_base = err_cnt;
    send_cmd(4'hF, 4'h0);
    check("clear_no_err", err_cnt - err_base, 0);
    measure(PERIOD);
    check("clear_led0", hi[0], 0);
    check("clear_led2", hi[2], 0);

    // Duty 5 on LED1 so a later reset has something to clear.
    send_cmd(4'h1, 4'h5);
    repeat (2) @(negedge clk);
    measure(PERIOD);
    check("led1_duty5", hi[1], 5 * PRESCALE);

    // Reset during WAIT_DATA.
    err_base = err_cnt;
    send_nibble(4'h2);
    check("midreset_busy_before", int'(bus.BUSY), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_busy", int'(bus.BUSY), 0);
    check("midreset_led", int'(bus.LED_OUT), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_no_err", err_cnt - err_base, 0);
    send_cmd(4'h3, 4'h4);
    repeat (2) @(negedge clk);
    measure(PERIOD);
    check("after_reset_led3", hi[3], 4 * PRESCALE);
    check("after_reset_led1", hi[1], 0);

    // Strobe held high across reset release must not start a command.
    err_base = err_cnt;
    bus.GPIO_1_M2F = 1'b1;
    bus.GPIO_4_M2F = 1'b1;
    bus.GPIO_0_M2F = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("held_strobe_busy", int'(bus.BUSY), 0);
    bus.GPIO_0_M2F = 1'b0;
    repeat (25) @(negedge clk);
    check("held_strobe_no_err", err_cnt - err_base, 0);

`ifdef GPIO_LED_BLINK_EN
    send_cmd(4'h3, 4'hF);
    send_cmd(4'h7, 4'h1);
    repeat (2) @(negedge clk);
    measure(32);
    check("blink_led3_half", hi[3], 16);
    err_base = err_cnt;
    send_cmd(4'h5, 4'h1);
    check("blink_cmd5_ok", err_cnt - err_base, 0);
`else
    send_cmd(4'h2, 4'h6);
    repeat (2) @(negedge clk);
    err_base = err_cnt;
    send_cmd(4'h5, 4'h1);
    check("cmd5_err_once", err_cnt - err_base, 1);
    measure(PERIOD);
    check("cmd5_led2_same", hi[2], 6 * PRESCALE);
    check("cmd5_led1_same", hi[1], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gpio_m2f_led_ctrl.md
GPIO_M2F_LED_CTRL -- requirements
Module: gpio_m2f_led_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, synchronizer depth for GPIO_x_M2F inputs (legal range 2..4).
REQ-002 Parameter PWM_PRESCALE, default 64, FAB_CCC_GL0 cycles per PWM step.
REQ-003 Parameter TIMEOUT_CYC, default 1024, maximum cycles between command nibble and data nibble.
REQ-004 Parameter BLINK_DIV, default 25000000, cycles per blink half-period.
REQ-005 FAB_CCC_GL0  input  1  sole clock, rising edge.
REQ-006 FAB_RESET_N  input  1  reset, synchronous, active-low.
REQ-007 GPIO_0_M2F  input  1  command strobe from MSS GPIO, asynchronous to FAB_CCC_GL0.
REQ-008 GPIO_1_M2F..GPIO_4_M2F  input  1 each  nibble bits 0..3 from MSS GPIO, asynchronous.
REQ-009 LED_OUT  output  4  per-channel LED drive, active-high, registered.
REQ-010 BUSY  output  1  high while the command FSM is not in IDLE.
REQ-011 CMD_ERR  output  1  one-cycle pulse on timeout or unknown command.

Function
REQ-012 All five GPIO inputs SHALL pass through identical SYNC_STAGES-deep synchronizers; the strobe rising edge SHALL be detected one cycle after the synchronized output.
REQ-013 The nibble SHALL be sampled from the synchronized data bits in the same cycle the strobe edge is detected.
REQ-014 FSM states: IDLE, WAIT_DATA, APPLY; IDLE->WAIT_DATA on edge (latch command nibble); WAIT_DATA->APPLY on edge (latch data nibble); APPLY->IDLE unconditionally after one cycle.
REQ-015 WAIT_DATA SHALL count cycles; on reaching TIMEOUT_CYC without an edge, go to IDLE, discard the command, pulse CMD_ERR.
REQ-016 An edge in the same cycle the timeout count expires SHALL be accepted as the data nibble (no CMD_ERR).
REQ-017 An edge while in APPLY SHALL be ignored.
REQ-018 Commands in APPLY: 0x0-0x3 write duty[n] = data; 0xF clear all duty and blink registers, data ignored; any other code pulse CMD_ERR, no register change.
REQ-019 Register write SHALL take effect in the APPLY cycle; LED_OUT reflects it no later than SYNC_STAGES+3 cycles after the synchronized strobe's raw rise plus one PWM step.
REQ-020 PWM step counter SHALL advance every PWM_PRESCALE cycles, counting 0..14 and wrapping to 0.
REQ-021 LED_OUT[n] = 0 when duty 0; = 1 constantly when duty 15; otherwise high while step < duty.
REQ-022 All channels SHALL share one PWM counter (phase-aligned).

Reset
REQ-023 While FAB_RESET_N is low at a clock edge: FSM to IDLE, all duty/blink registers 0, PWM/blink/timeout counters 0, synchronizer stages 0, LED_OUT 0, BUSY 0, CMD_ERR 0.
REQ-024 Reset asserted mid-command SHALL discard the partial command with no CMD_ERR pulse.
REQ-025 A synchronized strobe already high when reset deasserts SHALL NOT produce an edge.

Configuration
REQ-026 Macro GPIO_LED_BLINK_EN defined: commands 0x4-0x7 write blink[n] = data[0]; a free-running blink phase toggles every BLINK_DIV cycles; channels with blink[n]=1 drive LED_OUT[n] = PWM output AND phase.
REQ-027 Macro undefined: no blink registers or divider synthesized; 0x4-0x7 treated as unknown (CMD_ERR).

Structure
REQ-028 Package gpio_led_pkg SHALL hold command code constants, FSM state typedef, nibble/duty width constants, PWM wrap value 14.
REQ-029 Sub-module gpio_sync (parameterised depth, single-bit) SHALL be instantiated once per GPIO input.

Verification
REQ-030 Set duty LED2: nibble 0x2 strobe, nibble 0xA strobe -> LED_OUT[2] high 10 of every 15 PWM steps, other LEDs 0, no CMD_ERR.
REQ-031 Command 0x1 then no strobe for TIMEOUT_CYC cycles -> exactly one CMD_ERR pulse, BUSY falls, duty[1] unchanged.
REQ-032 Duty 15 on LED0 then command 0xF/0x0 -> LED_OUT[0] constantly high then 0 within one PWM period.
REQ-033 Command 0x9/0x3 -> CMD_ERR pulse in APPLY cycle, all LED_OUT unchanged; with macro off repeat for 0x5.
REQ-034 FAB_RESET_N low during WAIT_DATA -> BUSY 0, LED_OUT 0, no CMD_ERR; following valid command works normally.
REQ-035 Macro on, BLINK_DIV=8, duty[3]=15, blink[3]=1 -> LED_OUT[3] toggles every 8 cycles.
